rom_load_sequencer: RTL

- Sequences the ROM download path into the arcade core: decodes the HPS ioctl byte stream into per-region write strobes (CPU ROM, GFX ROM, PROMs) and re-times it onto the core's dn_addr/dn_data/dn_wr port.
- Owns the core reset: holds the core in reset from power-up until a complete, size-correct download has finished, then for a fixed settle time.
- Folds user reset requests (OSD reset, button) into that same reset sequence.
- Sits between hps_io and the pacman-family core in the emu top level.

---
 rtl/rom_load_sequencer_if.sv | 24 ++
 rtl/rom_load_sequencer.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/rom_load_sequencer_if.sv
// ROM download bus: hps_io ioctl byte stream in, core dn_* write port out.
// master = hps_io side driving ioctl_*, slave = the sequencer driving dn_*.
interface rom_load_sequencer_if;
  logic        ioctl_download;
  logic        ioctl_wr;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic [15:0] dn_addr;
  logic [7:0]  dn_data;
  logic        dn_wr;
  logic        cs_cpu;
  logic        cs_gfx;
  logic        cs_prom;

  modport master (
    output ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout,
    input  dn_addr, dn_data, dn_wr, cs_cpu, cs_gfx, cs_prom
  );

  modport slave (
    input  ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout,
    output dn_addr, dn_data, dn_wr, cs_cpu, cs_gfx, cs_prom
  );
endinterface

// File: rtl/rom_load_sequencer.sv
// ROM download sequencer: re-times ioctl bytes onto dn_*, decodes region
// selects, and owns core_reset (BOOT/LOAD/HOLD/RUN/FAIL).
// Ports: CLK, RESET (sync, active high), bus (slave modport), user_reset,
// core_reset, load_ok, load_err, byte_count.
// Optional: define LOADER_CHECKSUM_EN to add an 8-bit byte-sum check.
module rom_load_sequencer #(
  parameter int         CPU_SIZE    = 16384,
  parameter int         GFX_SIZE    = 8192,
  parameter int         PROM_SIZE   = 512,
  parameter int         HOLD_CYCLES = 1024,
  parameter logic [7:0] EXP_SUM     = 8'h00
) (
  input  logic                 CLK,
  input  logic                 RESET,
  rom_load_sequencer_if.slave  bus,
  input  logic                 user_reset,
  output logic                 core_reset,
  output logic                 load_ok,
  output logic                 load_err,
  output logic [15:0]          byte_count
);

  localparam int TOTAL     = CPU_SIZE + GFX_SIZE + PROM_SIZE;
  localparam int PROM_BASE = CPU_SIZE + GFX_SIZE;
  localparam int HW        = $clog2(HOLD_CYCLES + 1);
  localparam logic [HW-1:0] HOLD_LD = HW'(HOLD_CYCLES);

  typedef enum logic [2:0] {
    BOOT, LOAD, HOLD, RUN, FAIL
  } state_t;

  state_t        state;
  logic          dl_q;
  logic          ovf;
  logic [HW-1:0] hold_cnt;

  logic        rise;
  logic        fall;
  logic        in_win;
  logic        in_rng;
  logic        wr_ok;
  logic        oor;
  logic [15:0] cnt_base;
  logic [15:0] cnt_nxt;
  logic        ovf_nxt;
  logic        good;

`ifdef LOADER_CHECKSUM_EN
  logic [7:0] sum;
  logic [7:0] sum_nxt;
`else
  logic unused_exp_sum;
  assign unused_exp_sum = ^EXP_SUM;
`endif

  // The cycle on which ioctl_download drops still accepts a byte, so a
  // strobe coincident with the fall is counted before the check.
  always_comb begin
    rise     = bus.ioctl_download & ~dl_q;
    fall     = ~bus.ioctl_download & dl_q;
    in_win   = bus.ioctl_download | dl_q;
    in_rng   = bus.ioctl_addr < 25'(TOTAL);
    wr_ok    = bus.ioctl_wr & in_win & in_rng;
    oor      = bus.ioctl_wr & in_win & ~in_rng;
    cnt_base = rise ? 16'd0 : byte_count;
    cnt_nxt  = cnt_base;
    if (wr_ok && cnt_base != 16'hFFFF)
      cnt_nxt = cnt_base + 16'd1;
    ovf_nxt  = (ovf & ~rise) | oor;
    good     = (cnt_nxt == 16'(TOTAL)) & ~ovf_nxt;
`ifdef LOADER_CHECKSUM_EN
    sum_nxt  = (rise ? 8'd0 : sum)
             + (wr_ok ? bus.ioctl_dout : 8'd0);
    good     = good & (sum_nxt == EXP_SUM);
`endif
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state       <= BOOT;
      dl_q        <= 1'b0;
      ovf         <= 1'b0;
      hold_cnt    <= '0;
      byte_count  <= '0;
      core_reset  <= 1'b1;
      load_ok     <= 1'b0;
      load_err    <= 1'b0;
      bus.dn_wr   <= 1'b0;
      bus.dn_addr <= '0;
      bus.dn_data <= '0;
      bus.cs_cpu  <= 1'b0;
      bus.cs_gfx  <= 1'b0;
      bus.cs_prom <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      sum         <= '0;
`endif
    end else begin
      dl_q       <= bus.ioctl_download;
      byte_count <= cnt_nxt;
      ovf        <= ovf_nxt;
      bus.dn_wr  <= wr_ok;
`ifdef LOADER_CHECKSUM_EN
      sum        <= sum_nxt;
`endif
      if (wr_ok) begin
        bus.dn_addr <= bus.ioctl_addr[15:0];
        bus.dn_data <= bus.ioctl_dout;
        bus.cs_cpu  <= bus.ioctl_addr < 25'(CPU_SIZE);
        bus.cs_gfx  <= bus.ioctl_addr >= 25'(CPU_SIZE)
                     && bus.ioctl_addr < 25'(PROM_BASE);
        bus.cs_prom <= bus.ioctl_addr >= 25'(PROM_BASE);
      end

      unique case (state)
        BOOT: begin
          core_reset <= 1'b1;
          if (bus.ioctl_download) begin
            state    <= LOAD;
            load_ok  <= 1'b0;
            load_err <= 1'b0;
          end
        end
        LOAD: begin
          core_reset <= 1'b1;
          if (fall) begin
            if (good) begin
              state    <= HOLD;
              load_ok  <= 1'b1;
              hold_cnt <= HOLD_LD;
            end else begin
              state    <= FAIL;
              load_err <= 1'b1;
            end
          end
        end
        HOLD: begin
          if (bus.ioctl_download) begin
            state    <= LOAD;
            load_ok  <= 1'b0;
            load_err <= 1'b0;
          end else if (user_reset) begin
            hold_cnt <= HOLD_LD;
          end else if (hold_cnt == '0) begin
            state      <= RUN;
            core_reset <= 1'b0;
          end else begin
            hold_cnt <= hold_cnt - 1'b1;
          end
        end
        RUN: begin
          if (bus.ioctl_download) begin
            state      <= LOAD;
            core_reset <= 1'b1;
            load_ok    <= 1'b0;
            load_err   <= 1'b0;
          end else if (user_reset) begin
            state      <= HOLD;
            core_reset <= 1'b1;
            hold_cnt   <= HOLD_LD;
          end
        end
        FAIL: begin
          core_reset <= 1'b1;
          if (bus.ioctl_download) begin
            state    <= LOAD;
            load_ok  <= 1'b0;
            load_err <= 1'b0;
          end
        end
        default: begin
          state      <= BOOT;
          core_reset <= 1'b1;
        end
      endcase
    end
  end

endmodule
